uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver with 16x oversampling, configurable frame format (data bits, parity, stop bits), per-byte error flags and a valid/ready output stage. It sits between the board RX pin and the command decoder of the co-processor. It replaces the fixed 8N1 receiver wherever a configurable format, error reporting or back-pressure is needed.

## Interface

Parameters:
- CLOCK_FREQUENCY, 25000000: i_clk frequency in Hz.
- BAUD_RATE, 115200: line rate in baud.
- OVERSAMPLE, 16: ticks per bit; must be even and ≥ 8.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 8: output FIFO entries; power of two, ≥ 2. Used only with UART_RX_FIFO_EN.

Ports (clock and reset first):
- i_clk, input, 1: system clock, single clock domain.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_rx_serial, input, 1: asynchronous serial line; idles high.
- o_rx_data, output, DATA_BITS: received word, LSB first on the line.
- o_rx_parity_err, output, 1: parity mismatch flag for o_rx_data; qualified by o_rx_valid.
- o_rx_frame_err, output, 1: a stop bit sampled low for o_rx_data; qualified by o_rx_valid.
- o_rx_valid, output, 1: output word available.
- i_rx_ready, input, 1: consumer accepts the word when o_rx_valid and i_rx_ready are both high on a clock edge.
- o_overrun, output, 1: one-cycle pulse when a completed frame is dropped because the output stage is full.

## Operation

Input conditioning and tick generation:
- i_rx_serial passes through a 2-FF synchroniser, then a 3-sample majority filter clocked every i_clk.
- Tick divider: DIVISOR = CLOCK_FREQUENCY / (BAUD_RATE*OVERSAMPLE), with integer truncation. The divider counts DIVISOR-1 down to 0 and emits a 1-cycle tick at 0.
- The divider free-runs. The bit-phase counter (0..OVERSAMPLE-1) is reset to 0 when a falling edge is detected in IDLE.

State machine:
- IDLE: wait for the filtered line to go low, then go to START.
- START: on tick OVERSAMPLE/2-1 (mid-bit), check the line. If it is high, this is a false start: return to IDLE with no output. If it is low, go to DATA with bit index 0.
- DATA: sample at each mid-bit, shifting LSB first. After DATA_BITS samples, go to PARITY if PARITY≠0, else STOP.
- PARITY: sample the parity bit. Error if XOR(data, parity bit) is not 1 for odd parity, or not 0 for even parity.
- STOP: sample each stop bit at mid-bit. Any low sample sets the frame error. After the last stop sample, push {data, parity_err, frame_err} to the output stage, then go to IDLE immediately, so a back-to-back start bit is caught within the second half of the stop bit.
- A frame error does not suppress the push. If the line is low at the last stop sample, the next falling edge is not detected until the line returns high.

Output stage:
- A push while the output stage is full drops the new frame and pulses o_overrun. The stored contents are unchanged.
- A pop occurs when o_rx_valid and i_rx_ready are both high.
- When a push and a pop coincide while full, the push is accepted and no overrun is signalled.

## Timing

- Reset values: o_rx_valid = 0, o_rx_data = 0, o_rx_parity_err = 0, o_rx_frame_err = 0, o_overrun = 0. State is IDLE and the FIFO is empty. The synchroniser resets to 1.
- Reset asserted mid-frame aborts the frame with no output. After release, reception restarts from IDLE on the next falling edge.
- Latency: o_rx_valid rises 1 cycle after the final stop-bit mid-sample tick. Add 3 cycles of input path (sync + filter) relative to the line.
- o_rx_valid, o_rx_data and the error flags are registered. They hold stable while o_rx_valid=1 and i_rx_ready=0.

## Configuration

- UART_RX_FIFO_EN defined: the output stage is a FIFO of FIFO_DEPTH entries with registered outputs, showing the head entry. Full means FIFO_DEPTH entries are stored.
- UART_RX_FIFO_EN undefined: the output stage is a single holding register. FIFO_DEPTH is ignored. Full means o_rx_valid=1.

## Test plan

Common settings: CLOCK_FREQUENCY=16000000, BAUD_RATE=100000, OVERSAMPLE=16, so DIVISOR=10 and one bit is 160 cycles.

- 8N1, send 0xA5 with i_rx_ready=1 → one o_rx_valid pulse with o_rx_data=0xA5 and both error flags 0.
- 7E1: send 0x41 with a correct parity bit (0), then the same data with parity bit 1 → the first word has parity_err=0, the second has data=0x41 and parity_err=1.
- 8N2: send 0x3C with the second stop bit forced low → data=0x3C and frame_err=1.
- Glitch: drive the line low for 40 cycles, then return it high → no o_rx_valid and the receiver returns to IDLE. A following 0x55 frame is received correctly.
- i_rx_ready=0; send 3 back-to-back frames (0x01, 0x02, 0x03).
  - Without the macro: 0x01 is held, and two o_overrun pulses occur.
  - With the macro and FIFO_DEPTH=2: 0x01 and 0x02 are held, and one o_overrun pulse occurs.
  - Then raise i_rx_ready → the held words are popped in order.
- Assert i_rst_n=0 during the data bits of a frame, release it, then send 0x5A → all outputs are 0 while in reset, the aborted frame produces no output, and 0x5A is received cleanly.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 16x-style oversampling.
// Frame format (data bits, parity, stop bits) is set by parameters. Each
// received word carries a parity-error and a frame-error flag. Words leave
// through a valid/ready stage.
// Optional feature macro: UART_RX_FIFO_EN. When it is defined, the output
// stage is a FIFO_DEPTH-entry FIFO. Otherwise it is a single holding register.
module uart_rx_param #(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int BAUD_RATE       = 115200,
  parameter int OVERSAMPLE      = 16,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_serial,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_overrun
);

  localparam int DIVISOR = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int PH_W    = $clog2(OVERSAMPLE);
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam int WORD_W  = DATA_BITS + 2;

  // Elaboration-time guard against illegal parameter combinations.
  if (DIVISOR < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic [1:0]            filt_hist;
  logic                  rx_filt;
  logic                  rx_prev;
  logic                  fall;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic [PH_W-1:0]       phase;
  logic                  mid_tick;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_err;
  logic                  frm_err;
  logic                  push;
  logic [WORD_W-1:0]     push_word;
  logic                  pop;

  // Two-flop synchroniser, then a two-deep history for the majority vote.
  // The line idles high, so both reset to 1.
  // NOTE: registers take non-blocking (<=) assignments so every flop samples
  // the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q    <= 2'b11;
      filt_hist <= 2'b11;
      rx_prev   <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], i_rx_serial};
      filt_hist <= {filt_hist[0], sync_q[1]};
      rx_prev   <= rx_filt;
    end
  end

  // Majority of the newest synchronised sample and the two before it.
  assign rx_filt = (sync_q[1] & filt_hist[0]) | (sync_q[1] & filt_hist[1]) |
                   (filt_hist[0] & filt_hist[1]);
  assign fall    = rx_prev & ~rx_filt;

  // Free-running tick divider: counts DIVISOR-1 down to 0 and ticks at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         div_cnt <= DIV_W'(DIVISOR - 1);
    else if (div_cnt == 0) div_cnt <= DIV_W'(DIVISOR - 1);
    else                  div_cnt <= div_cnt - DIV_W'(1);
  end

  assign tick = (div_cnt == 0);

  // Bit-phase counter. It realigns on the start edge so that mid-bit falls
  // OVERSAMPLE/2 ticks after the detected falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       phase <= '0;
    else if (state_q == S_IDLE && fall) phase <= '0;
    else if (tick)                      phase <= (phase == PH_W'(OVERSAMPLE - 1)) ? '0 : phase + PH_W'(1);
  end

  assign mid_tick = tick && (phase == PH_W'(OVERSAMPLE / 2 - 1));

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and the push strobe at the final stop-bit sample.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE:   if (fall) state_d = S_START;
      S_START:  if (mid_tick) state_d = rx_filt ? S_IDLE : S_DATA;
      S_DATA: begin
        if (mid_tick && bit_idx == IDX_W'(DATA_BITS - 1))
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (mid_tick) state_d = S_STOP;
      S_STOP: begin
        if (mid_tick && stop_idx == 1'(STOP_BITS - 1)) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame datapath: shifts data LSB first and accumulates the error flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else if (mid_tick) begin
      case (state_q)
        S_START: begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          par_err  <= 1'b0;
          frm_err  <= 1'b0;
        end
        S_DATA: begin
          shreg   <= {rx_filt, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + IDX_W'(1);
        end
        S_PARITY: par_err <= (PARITY == 1) ? ~(^shreg ^ rx_filt) : (^shreg ^ rx_filt);
        S_STOP: begin
          if (!rx_filt) frm_err <= 1'b1;
          stop_idx <= stop_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The current stop sample is folded in directly because it is taken on
  // the same edge as the push.
  assign push_word = {shreg, par_err, frm_err | ~rx_filt};
  assign pop       = o_rx_valid & i_rx_ready;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CW-1:0]     count, count_left;
  logic              full, wr_en, valid_nxt;
  logic [WORD_W-1:0] head_nxt;

  // FIFO bookkeeping and the next head word. When the FIFO is full, a push
  // that coincides with a pop reuses the slot that the pop frees.
  always_comb begin
    full       = (count == CW'(FIFO_DEPTH));
    wr_en      = push && (!full || pop);
    count_left = count - CW'(pop);
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    valid_nxt  = (count_left != 0) || wr_en;
    head_nxt   = (count_left == 0) ? push_word : mem[rd_ptr_nxt];
  end

  // Storage array write port.
  // NOTE: the storage array has no reset. The count and the valid flag
  // decide which entries are meaningful, so clearing the array is unneeded.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  // Pointers, occupancy and the registered head-of-FIFO outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      o_rx_valid      <= 1'b0;
      o_rx_data       <= '0;
      o_rx_parity_err <= 1'b0;
      o_rx_frame_err  <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      count      <= count + CW'(wr_en) - CW'(pop);
      o_rx_valid <= valid_nxt;
      o_overrun  <= push && !wr_en;
      if (valid_nxt) {o_rx_data, o_rx_parity_err, o_rx_frame_err} <= head_nxt;
    end
  end
`else
  // Single holding register. A push is dropped only if the register stays
  // occupied through this edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rx_valid      <= 1'b0;
      o_rx_data       <= '0;
      o_rx_parity_err <= 1'b0;
      o_rx_frame_err  <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      o_overrun <= push && o_rx_valid && !pop;
      if (push && (!o_rx_valid || pop)) begin
        {o_rx_data, o_rx_parity_err, o_rx_frame_err} <= push_word;
        o_rx_valid <= 1'b1;
      end else if (pop) begin
        o_rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: three instances (8N1, 7E1, 8N2) at
// 16 MHz / 100 kBd / 16x oversampling, so one bit lasts 160 clocks.
// Vector table for single frames, plus hand-written sequences for glitch,
// overrun/back-pressure and mid-frame reset.
module tb_uart_rx_param;

  localparam int CLK_HZ = 16000000;
  localparam int BAUD   = 100000;
  localparam int OS     = 16;
  localparam int BIT    = 160;
  localparam int NVEC   = 11;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       par_flip;
    logic       stop1;
    logic       stop2;
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxl, rdy, vld, pe, fe, ovr;
  logic [7:0] d0, d2;
  logic [6:0] d1;

  word_t q0[$], q1[$], q2[$];
  int    ovr_cnt[3] = '{0, 0, 0};
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(2)) u_8n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rxl[0]), .o_rx_data(d0),
    .o_rx_parity_err(pe[0]), .o_rx_frame_err(fe[0]), .o_rx_valid(vld[0]),
    .i_rx_ready(rdy[0]), .o_overrun(ovr[0]));

  uart_rx_param #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) u_7e1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rxl[1]), .o_rx_data(d1),
    .o_rx_parity_err(pe[1]), .o_rx_frame_err(fe[1]), .o_rx_valid(vld[1]),
    .i_rx_ready(rdy[1]), .o_overrun(ovr[1]));

  uart_rx_param #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8)) u_8n2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rxl[2]), .o_rx_data(d2),
    .o_rx_parity_err(pe[2]), .o_rx_frame_err(fe[2]), .o_rx_valid(vld[2]),
    .i_rx_ready(rdy[2]), .o_overrun(ovr[2]));

  // Record every accepted word and every overrun pulse, away from the edge.
  always @(negedge clk) begin
    if (vld[0] && rdy[0]) q0.push_back('{{1'b0, d0}, pe[0], fe[0]});
    if (vld[1] && rdy[1]) q1.push_back('{{2'b00, d1}, pe[1], fe[1]});
    if (vld[2] && rdy[2]) q2.push_back('{{1'b0, d2}, pe[2], fe[2]});
    for (int i = 0; i < 3; i++) if (ovr[i]) ovr_cnt[i]++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop_word(input int inst, output word_t w);
    case (inst)
      0:       w = q0.pop_front();
      1:       w = q1.pop_front();
      default: w = q2.pop_front();
    endcase
  endtask

  task automatic set_line(input int inst, input logic v);
    rxl[inst] = v;
  endtask

  // Builds the serial bit sequence (start, data LSB first, parity, stops).
  task automatic build_frame(input int inst, input logic [8:0] data, input logic par_flip,
                             input logic s1, input logic s2,
                             output logic [12:0] bits, output int n);
    int nb;
    int k;
    nb   = (inst == 1) ? 7 : 8;
    bits = '1;
    k    = 0;
    bits[k] = 1'b0; k++;
    for (int i = 0; i < nb; i++) begin bits[k] = data[i]; k++; end
    if (inst == 1) begin bits[k] = (^data[6:0]) ^ par_flip; k++; end
    bits[k] = s1; k++;
    if (inst == 2) begin bits[k] = s2; k++; end
    n = k;
  endtask

  task automatic drive_bits(input int inst, input logic [12:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      set_line(inst, bits[i]);
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input logic par_flip,
                            input logic s1, input logic s2);
    logic [12:0] bits;
    int          n;
    build_frame(inst, data, par_flip, s1, s2, bits, n);
    drive_bits(inst, bits, 0, n - 1);
    set_line(inst, 1'b1);
  endtask

  task automatic expect_word(input string tag, input int inst, input logic [8:0] d,
                             input logic p, input logic f);
    word_t w;
    int    n;
    n = qsize(inst);
    check({tag, " present"}, (n > 0) ? 32'd1 : 32'd0, 32'd1);
    if (n > 0) begin
      pop_word(inst, w);
      check({tag, " data"}, 32'(w.d), 32'(d));
      check({tag, " parity_err"}, 32'(w.pe), 32'(p));
      check({tag, " frame_err"}, 32'(w.fe), 32'(f));
    end
  endtask

  initial begin
    vec_t vecs[NVEC];
    int   base;
    int   exp_ovr;
    logic [12:0] bits;
    int   n;

    //            inst data    flip  stop1 stop2 exp_d   pe    fe
    vecs[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[3]  = '{1, 9'h041, 1'b0, 1'b1, 1'b1, 9'h041, 1'b0, 1'b0};
    vecs[4]  = '{1, 9'h041, 1'b1, 1'b1, 1'b1, 9'h041, 1'b1, 1'b0};
    vecs[5]  = '{1, 9'h07F, 1'b0, 1'b1, 1'b1, 9'h07F, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h02A, 1'b0, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b1};
    vecs[7]  = '{2, 9'h03C, 1'b0, 1'b1, 1'b0, 9'h03C, 1'b0, 1'b1};
    vecs[8]  = '{2, 9'h0C3, 1'b0, 1'b1, 1'b1, 9'h0C3, 1'b0, 1'b0};
    vecs[9]  = '{2, 9'h081, 1'b0, 1'b0, 1'b1, 9'h081, 1'b0, 1'b1};
    vecs[10] = '{0, 9'h05A, 1'b0, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b1};

    rst_n = 1'b0;
    rxl   = 3'b111;
    rdy   = 3'b111;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset valid", 32'(vld), 32'd0);
    check("reset data", 32'(d0), 32'd0);
    check("reset parity_err", 32'(pe[0]), 32'd0);
    check("reset frame_err", 32'(fe[0]), 32'd0);
    check("reset overrun", 32'(ovr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;

    // Single frames from the table.
    for (int i = 0; i < NVEC; i++) begin
      send_frame(vecs[i].inst, vecs[i].data, vecs[i].par_flip, vecs[i].stop1, vecs[i].stop2);
      repeat (20) @(posedge clk); #1;
      expect_word($sformatf("vec%0d", i), vecs[i].inst, vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
      check($sformatf("vec%0d extra", i), 32'(qsize(vecs[i].inst)), 32'd0);
    end

    // Glitch shorter than half a bit: false start, no output.
    set_line(0, 1'b0);
    repeat (40) @(posedge clk); #1;
    set_line(0, 1'b1);
    repeat (300) @(posedge clk); #1;
    check("glitch no word", 32'(qsize(0)), 32'd0);
    send_frame(0, 9'h055, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    expect_word("after glitch", 0, 9'h055, 1'b0, 1'b0);

    // Back-pressure: three back-to-back frames with ready low.
    rdy[0] = 1'b0;
    base   = ovr_cnt[0];
    send_frame(0, 9'h001, 1'b0, 1'b1, 1'b1);
    send_frame(0, 9'h002, 1'b0, 1'b1, 1'b1);
    send_frame(0, 9'h003, 1'b0, 1'b1, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
`ifdef UART_RX_FIFO_EN
    exp_ovr = 1;
`else
    exp_ovr = 2;
`endif
    check("held valid", 32'(vld[0]), 32'd1);
    check("held data", 32'(d0), 32'h01);
    check("overrun pulses", 32'(ovr_cnt[0] - base), 32'(exp_ovr));
    repeat (100) @(negedge clk);
    check("held data stable", 32'(d0), 32'h01);
    check("nothing accepted", 32'(qsize(0)), 32'd0);
    @(posedge clk); #1;
    rdy[0] = 1'b1;
    repeat (10) @(posedge clk); #1;
    expect_word("pop first", 0, 9'h001, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_EN
    expect_word("pop second", 0, 9'h002, 1'b0, 1'b0);
`endif
    check("pop extra", 32'(qsize(0)), 32'd0);
    check("empty after pop", 32'(vld[0]), 32'd0);

    // Reset during data bits, with a word held at the output beforehand.
    rdy[0] = 1'b0;
    send_frame(0, 9'h0C3, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("pre-reset held data", 32'(d0), 32'hC3);
    @(posedge clk); #1;
    base = ovr_cnt[0];
    build_frame(0, 9'h077, 1'b0, 1'b1, 1'b1, bits, n);
    drive_bits(0, bits, 0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("in-reset valid", 32'(vld[0]), 32'd0);
    check("in-reset data", 32'(d0), 32'd0);
    check("in-reset flags", 32'({pe[0], fe[0], ovr[0]}), 32'd0);
    @(posedge clk); #1;
    drive_bits(0, bits, 4, n - 1);
    set_line(0, 1'b1);
    rst_n  = 1'b1;
    rdy[0] = 1'b1;
    repeat (300) @(posedge clk); #1;
    check("aborted frame no word", 32'(qsize(0)), 32'd0);
    check("aborted frame no overrun", 32'(ovr_cnt[0] - base), 32'd0);
    send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    expect_word("after reset", 0, 9'h05A, 1'b0, 1'b0);
    check("after reset extra", 32'(qsize(0)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
